// File: rtl/downsampler_scheduler.sv
// Paces 4x-rate samples into the polyphase downsampler: one strobe every SLOT
// cycles, fed from a small input FIFO; registers the decimated result out.
// Latency: strobe, sample, underrun and phase are registered one cycle after the
// strobe cycle; sample_out follows ds_result_valid by one cycle.
// Backpressure: src_ready drops only when the FIFO is full; an empty FIFO on a
// strobe cycle issues a zero-filled strobe and counts an underrun.

// Generic synchronous FIFO with registered occupancy count.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Storage is data-only; nothing reads a slot before it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module downsampler_scheduler #(
  parameter int PERIOD     = 2272,
  parameter int RATIO      = 4,
  parameter int MIN_GAP    = 260,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [15:0]                   src_sample,
  input  logic                          src_valid,
  output logic                          src_ready,
  output logic [15:0]                   ds_sample,
  output logic                          ds_valid,
  input  logic [15:0]                   ds_result,
  input  logic                          ds_result_valid,
  output logic [15:0]                   sample_out,
  output logic                          sample_out_valid,
  output logic [1:0]                    phase,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [15:0]                   underrun_count
);
  localparam int SLOT   = PERIOD / RATIO;
  localparam int SLOT_W = (SLOT > 1) ? $clog2(SLOT) : 1;

  // Reject parameter sets the downsampler cannot handle.
  generate
    if ((PERIOD % RATIO) != 0 || SLOT < MIN_GAP || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("downsampler_scheduler: invalid PERIOD/RATIO/MIN_GAP/FIFO_DEPTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2
  } sched_state_t;

  sched_state_t      state;
  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] slot_nxt;
  logic              strobe;

  logic              fifo_push;
  logic              fifo_pop;
  logic [15:0]       fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (src_sample),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Ready depends only on the registered count, never on src_valid.
  assign src_ready = !fifo_full;
  assign fifo_push = src_valid && src_ready;
  // The registered count decides the pop, so a same-cycle push into an empty FIFO still underruns.
  assign strobe    = (state == ST_STROBE);
  assign fifo_pop  = strobe && !fifo_empty;

  // Slot counter register: the scheduler state is implied by its value and enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_nxt;
    end
  end

  // Decode state from slot position and compute the next slot position.
  always_comb begin
    state    = ST_IDLE;
    slot_nxt = '0;
    if (enable) begin
      state    = (slot_cnt == '0) ? ST_STROBE : ST_WAIT;
      slot_nxt = (slot_cnt == SLOT_W'(SLOT - 1)) ? '0 : slot_cnt + 1'b1;
    end
  end

  // Strobe outputs: sample or zero-fill, phase step, underrun pulse and saturating count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_sample      <= '0;
      ds_valid       <= 1'b0;
      underrun       <= 1'b0;
      phase          <= '0;
      underrun_count <= '0;
    end else begin
      ds_valid <= strobe;
      underrun <= strobe && fifo_empty;
      if (strobe) begin
        ds_sample <= fifo_empty ? 16'd0 : fifo_head;
        phase     <= phase + 1'b1;
        if (fifo_empty && underrun_count != 16'hFFFF) begin
          underrun_count <= underrun_count + 1'b1;
        end
      end else if (!enable) begin
        phase <= '0;
      end
    end
  end

  // Capture the decimated result; the value holds between result strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
    end else begin
      sample_out_valid <= ds_result_valid;
      if (ds_result_valid) begin
        sample_out <= ds_result;
      end
    end
  end
endmodule

// File: tb/tb_downsampler_scheduler.sv
// Scoreboard bench: the stimulus process advances a queue-based reference model
// and posts expected strobes/results; a negedge monitor compares the DUT outputs.
// A second instance with a one-cycle slot drives the underrun counter into saturation.
module tb_downsampler_scheduler;
  localparam int PERIOD = 2272;
  localparam int RATIO  = 4;
  localparam int SLOT   = PERIOD / RATIO;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] src_sample = '0;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic [15:0] ds_sample;
  logic        ds_valid;
  logic [15:0] ds_result = '0;
  logic        ds_result_valid = 1'b0;
  logic [15:0] sample_out;
  logic        sample_out_valid;
  logic [1:0]  phase;
  logic [3:0]  fifo_level;
  logic        underrun;
  logic [15:0] underrun_count;

  // Saturation instance signals
  logic        rst2 = 1'b1;
  logic        enable2 = 1'b0;
  logic [15:0] src_sample2 = '0;
  logic        src_valid2 = 1'b0;
  logic        src_ready2;
  logic [15:0] ds_sample2;
  logic        ds_valid2;
  logic [15:0] ds_result2 = '0;
  logic        ds_result_valid2 = 1'b0;
  logic [15:0] sample_out2;
  logic        sample_out_valid2;
  logic [1:0]  phase2;
  logic [3:0]  fifo_level2;
  logic        underrun2;
  logic [15:0] underrun_count2;

  downsampler_scheduler #(.PERIOD(PERIOD), .RATIO(RATIO), .MIN_GAP(260), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .src_sample(src_sample), .src_valid(src_valid), .src_ready(src_ready),
    .ds_sample(ds_sample), .ds_valid(ds_valid),
    .ds_result(ds_result), .ds_result_valid(ds_result_valid),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .phase(phase), .fifo_level(fifo_level),
    .underrun(underrun), .underrun_count(underrun_count)
  );

  downsampler_scheduler #(.PERIOD(2), .RATIO(2), .MIN_GAP(1), .FIFO_DEPTH(DEPTH)) dut_sat (
    .clk(clk), .rst(rst2), .enable(enable2),
    .src_sample(src_sample2), .src_valid(src_valid2), .src_ready(src_ready2),
    .ds_sample(ds_sample2), .ds_valid(ds_valid2),
    .ds_result(ds_result2), .ds_result_valid(ds_result_valid2),
    .sample_out(sample_out2), .sample_out_valid(sample_out_valid2),
    .phase(phase2), .fifo_level(fifo_level2),
    .underrun(underrun2), .underrun_count(underrun_count2)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit sat_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int tag; logic [15:0] val; bit ur; } ds_exp_t;
  typedef struct { int tag; logic [15:0] val; } out_exp_t;

  ds_exp_t     sb[$];
  out_exp_t    oq[$];
  logic [15:0] mq[$];
  int          run, strobes, ucnt;
  int          snap_level, snap_phase, snap_ucnt;
  logic [15:0] exp_so;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic void reset_model();
    sb.delete(); oq.delete(); mq.delete();
    run = 0; strobes = 0; ucnt = 0;
    snap_level = 0; snap_phase = 0; snap_ucnt = 0;
    exp_so = '0;
  endfunction

  // One clock of stimulus; the model computes what the next edge must produce.
  task automatic step(input bit r, input bit en, input bit v, input logic [15:0] d,
                      input bit rv, input logic [15:0] rd);
    int sz0;
    ds_exp_t e;
    @(posedge clk); #1;
    rst = r; enable = en; src_valid = v; src_sample = d;
    ds_result_valid = rv; ds_result = rd;
    if (r) begin
      reset_model();
      return;
    end
    snap_level = mq.size();
    snap_phase = strobes % RATIO;
    snap_ucnt  = ucnt;
    sz0 = mq.size();
    if (en && (run % SLOT) == 0) begin
      e.tag = cyc + 1;
      if (sz0 > 0) begin
        e.val = mq.pop_front();
        e.ur  = 1'b0;
      end else begin
        e.val = '0;
        e.ur  = 1'b1;
        if (ucnt < 65535) ucnt++;
      end
      strobes++;
      sb.push_back(e);
    end
    if (en) run++;
    else begin
      run = 0;
      strobes = 0;
    end
    if (v && sz0 < DEPTH) mq.push_back(d);
    if (rv) oq.push_back('{cyc + 1, rd});
  endtask

  task automatic idle(input bit en, input int n);
    for (int i = 0; i < n; i++) step(0, en, 0, '0, 0, '0);
  endtask

  // Monitor: compare every output against the model once per cycle.
  ds_exp_t  mon_e;
  out_exp_t mon_o;
  bit       mon_strobe;
  always @(negedge clk) begin
    mon_strobe = (sb.size() > 0) && (sb[0].tag == cyc);
    chk("ds_valid", ds_valid, mon_strobe);
    if (mon_strobe) begin
      mon_e = sb.pop_front();
      chk("ds_sample", ds_sample, mon_e.val);
      chk("underrun", underrun, mon_e.ur);
    end else begin
      chk("underrun_idle", underrun, 0);
    end
    chk("fifo_level", fifo_level, snap_level);
    chk("src_ready", src_ready, snap_level < DEPTH);
    chk("phase", phase, snap_phase);
    chk("underrun_count", underrun_count, snap_ucnt);
    if (oq.size() > 0 && oq[0].tag == cyc) begin
      mon_o = oq.pop_front();
      exp_so = mon_o.val;
      chk("sample_out_valid", sample_out_valid, 1);
    end else begin
      chk("sample_out_valid_idle", sample_out_valid, 0);
    end
    chk("sample_out", sample_out, exp_so);
  end

  // Main stimulus sequence
  initial begin
    reset_model();
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0, '0);
    idle(0, 2);

    // Preload 1..8, then one rejected push while full, then run five slots
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 16'(i), 0, '0);
    step(0, 0, 1, 16'h0099, 0, '0);
    idle(0, 3);
    idle(1, 5 * SLOT + 2);

    // Random traffic, random result strobes
    for (int i = 0; i < 20 * SLOT; i++) begin
      step(0, 1, ($urandom_range(0, 399) == 0), 16'($urandom),
           ($urandom_range(0, 999) == 0), 16'($urandom));
    end

    // Queue two samples, then drop enable at slot position 300 for 10 cycles
    step(0, 1, 1, 16'h0A01, 0, '0);
    step(0, 1, 1, 16'h0A02, 0, '0);
    for (int i = 0; i < SLOT && (run % SLOT) != 300; i++) idle(1, 1);
    idle(0, 10);
    idle(1, 3 * SLOT);

    // Drain, then push into the empty FIFO on a strobe cycle
    for (int i = 0; i < 10 * SLOT && mq.size() > 0; i++) idle(1, 1);
    for (int i = 0; i < SLOT && (run % SLOT) != 0; i++) idle(1, 1);
    step(0, 1, 1, 16'h0ABC, 0, '0);
    idle(1, 2 * SLOT + 5);

    // Directed result capture
    step(0, 1, 0, '0, 1, 16'h1234);
    idle(1, 5);

    // Fill to five entries and reach mid-slot, then reset asynchronously
    for (int i = 0; i < 20 && mq.size() < 5; i++) step(0, 1, 1, 16'(16'h0B00 + i), 0, '0);
    for (int i = 0; i < SLOT && (run % SLOT) != 250; i++) step(0, 1, (mq.size() < 5), 16'h0C55, 0, '0);
    #2 rst = 1'b1;
    #1;
    chk("arst_ds_valid", ds_valid, 0);
    chk("arst_ds_sample", ds_sample, 0);
    chk("arst_sample_out", sample_out, 0);
    chk("arst_sample_out_valid", sample_out_valid, 0);
    chk("arst_phase", phase, 0);
    chk("arst_fifo_level", fifo_level, 0);
    chk("arst_src_ready", src_ready, 1);
    chk("arst_underrun", underrun, 0);
    chk("arst_underrun_count", underrun_count, 0);
    reset_model();
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0, '0);
    idle(0, 4);
    idle(1, SLOT + 3);

    // Keep the model in step while the saturation run completes
    for (int i = 0; i < 80000 && !sat_done; i++) idle(0, 1);
    chk("sat_finished", sat_done, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Saturation run: every cycle is an underrunning strobe
  int sat_n = 0;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst2 = 1'b0;
    enable2 = 1'b1;
    for (int c = 0; c < 70000 && sat_n < 65540; c++) begin
      @(negedge clk);
      if (ds_valid2) begin
        sat_n++;
        if (sat_n <= 3 || (sat_n >= 65534 && sat_n <= 65536) || sat_n == 65540) begin
          chk("sat_count", underrun_count2, (sat_n > 65535) ? 65535 : sat_n);
          chk("sat_underrun", underrun2, 1);
          chk("sat_ds_sample", ds_sample2, 0);
        end
      end
    end
    chk("sat_strobes", sat_n, 65540);
    sat_done = 1'b1;
  end
endmodule

// File: doc/downsampler_scheduler.md
# downsampler_scheduler

Sequencer in front of the polyphase 4:1 downsampler. Buffers 4x-rate input samples from an upstream producer through a small FIFO and issues exactly one single-cycle input strobe to the downsampler every SLOT clock cycles. Tracks polyphase phase and counts underruns. Registers the downsampler's decimated result onto the system-rate output. Sits between the oversampled synthesis path and the 1x-rate audio sink.

## Interface
- PERIOD, 2272: output sample period in clk cycles.
- RATIO, 4: decimation ratio; SLOT = PERIOD/RATIO = 568 cycles between strobes.
- MIN_GAP, 260: minimum strobe spacing the downsampler tolerates; elaboration error if SLOT < MIN_GAP or PERIOD % RATIO != 0.
- FIFO_DEPTH, 8: input FIFO entries, power of two.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  run scheduler; low holds slot/phase counters at 0.
- src_sample  in  16  signed 4x-rate input sample.
- src_valid  in  1  src_sample valid.
- src_ready  out  1  FIFO can accept; transfer when src_valid & src_ready.
- ds_sample  out  16  sample to downsampler.
- ds_valid  out  1  one-cycle strobe to downsampler.
- ds_result  in  16  downsampler output sample.
- ds_result_valid  in  1  downsampler output strobe.
- sample_out  out  16  registered decimated sample.
- sample_out_valid  out  1  one-cycle strobe, once per PERIOD in steady state.
- phase  out  2  number of strobes issued mod RATIO.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underrun  out  1  one-cycle pulse coincident with a zero-filled ds_valid.
- underrun_count  out  16  saturating count of underruns.

## Operation
- FIFO: synchronous, registered count. src_ready = (count != FIFO_DEPTH). Push on src_valid & src_ready.
- slot_cnt counts 0..SLOT-1 and wraps while enable=1. It is forced to 0 while enable=0.
- Strobe decision: a cycle with enable=1 and slot_cnt==0 is a strobe cycle.
  - Count > 0: pop the head into ds_sample.
  - Count == 0: ds_sample <= 0, pulse underrun, increment underrun_count, saturating at 16'hFFFF.
- Strobe side effects: ds_valid pulses for one cycle and phase increments, wrapping 3 -> 0.
- Simultaneous push and pop: both occur and the count is unchanged.
- Push into an empty FIFO on a strobe cycle: the strobe still underruns, since the registered count is 0. The pushed sample remains queued.
- enable falling: slot_cnt and phase clear next cycle. FIFO contents and underrun_count are retained. No strobe is issued while enable=0.
- Output: on ds_result_valid, sample_out <= ds_result and sample_out_valid pulses. Otherwise sample_out holds. No phase checking.
- States, implicit in slot_cnt:
  - IDLE: enable=0.
  - STROBE: slot_cnt==0.
  - WAIT: slot_cnt 1..SLOT-1.
- Reset (async, any time, including mid-slot) sets the following. The FIFO contents are discarded.
  - src_ready=1 after reset, because the count is 0.
  - ds_sample=0, ds_valid=0, sample_out=0, sample_out_valid=0, phase=0.
  - fifo_level=0, underrun=0, underrun_count=0.
  - slot_cnt=0.

## Timing
- Strobe latency: ds_valid, ds_sample, underrun and the phase update are registered and appear the cycle after the strobe cycle.
- First strobe: enable rising at cycle t (first cycle sampled high) gives ds_valid at t+1. Subsequent strobes follow at t+1+k*SLOT.
- Strobe spacing: exactly SLOT cycles apart while enable stays high.
- src_ready reflects the count after the previous edge, so there is no combinational path from src_valid.
- FIFO push-to-visible: a sample pushed at edge e is eligible for a strobe cycle at e+1 or later.
- sample_out_valid is ds_result_valid delayed by exactly 1 cycle.
- Throughput: the upstream must average at least one sample per SLOT cycles to avoid underrun. Bursts up to FIFO_DEPTH are absorbed.

## Test plan
- Reset, then preload 8 samples 1..8 and raise enable → ds_valid at enable+1, +569, +1137, …, carrying 1,2,3,… in order. phase steps 1,2,3,0. src_ready stays 0 until the first pop, then goes 1.
- Empty FIFO with enable=1 → ds_valid with ds_sample=0, underrun pulses with each strobe, and underrun_count increments 1,2,3. Force 65540 underruns → underrun_count saturates at 65535.
- Push on the same cycle as a strobe cycle into an empty FIFO → that strobe underruns with 0. The next strobe, SLOT later, delivers the pushed value. fifo_level reads 1 in between.
- Drop enable mid-slot (slot_cnt=300) and re-raise 10 cycles later → no strobe during the gap, first new strobe 1 cycle after the re-raise, phase restarts at 1, FIFO contents preserved.
- Drive ds_result=16'h1234 with a ds_result_valid pulse → sample_out=16'h1234 and sample_out_valid high for exactly one cycle, 1 cycle later. Value holds afterward.
- Assert rst asynchronously mid-slot with 5 samples queued → all outputs return to reset values immediately, without waiting for a clk edge. fifo_level=0 and src_ready=1 after release.
